// File: rtl/exception_sequencer.sv
// exception_sequencer
//   Sequences exception entry and IRET exit through the single-write-port
//   system register file. Entry flushes the pipeline, saves EPC, BADADDR,
//   CAUSE and STATUS one write per cycle, then redirects to HANDLER_VEC.
//   IRET reads EPC back, clears STATUS and redirects to the saved EPC.
//
// Ports
//   clk, rst_n                          clock, synchronous active-low reset
//   itlb_miss, dtlb_miss, illegal, irq  exception sources
//   iret                                IRET committing this cycle
//   fault_pc, fault_addr                faulting PC / TLB-miss address
//   supervisor                          STATUS bit0 from the system regfile
//   sys_we, sys_waddr, sys_wdata        system regfile write port
//   sys_raddr, sys_rdata                system regfile read port (combinational)
//   flush, stall                        pipeline control
//   pc_redirect, pc_target              one-cycle PC load strobe and target
//
// Configuration
//   EXC_IRQ_EN  when defined, irq is taken in user mode (supervisor = 0) as
//               cause 4; when undefined, irq is ignored.

module exception_sequencer #(
    parameter logic [31:0] HANDLER_VEC = 32'h0000_2000,
    parameter logic [4:0]  EPC_IDX     = 5'd0,
    parameter logic [4:0]  BAD_IDX     = 5'd1,
    parameter logic [4:0]  CAUSE_IDX   = 5'd2,
    parameter logic [4:0]  STATUS_IDX  = 5'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        itlb_miss,
    input  logic        dtlb_miss,
    input  logic        illegal,
    input  logic        irq,
    input  logic        iret,
    input  logic [31:0] fault_pc,
    input  logic [31:0] fault_addr,
    input  logic        supervisor,
    output logic        sys_we,
    output logic [4:0]  sys_waddr,
    output logic [31:0] sys_wdata,
    output logic [4:0]  sys_raddr,
    input  logic [31:0] sys_rdata,
    output logic        flush,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target
);

    typedef enum logic [3:0] {
        StIdle,
        StFlush,
        StSaveEpc,
        StSaveBad,
        StSaveCause,
        StSaveStatus,
        StRedirect,
        StIretRd,
        StIretWr,
        StIretRedir
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic        irq_take;

`ifdef EXC_IRQ_EN
    assign irq_take = irq & ~supervisor;
`else
    logic unused_irq;
    assign unused_irq = irq;
    assign irq_take   = 1'b0;
`endif

    // The read port only ever needs EPC.
    assign sys_raddr = EPC_IDX;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            addr_q  <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    // Next-state and capture logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        unique case (state_q)
            StIdle: begin
                if (dtlb_miss || itlb_miss || illegal || irq_take || iret) begin
                    pc_d    = fault_pc;
                    addr_d  = fault_addr;
                    state_d = StFlush;
                    if (dtlb_miss)      cause_d = 3'd2;
                    else if (itlb_miss) cause_d = 3'd1;
                    else if (illegal)   cause_d = 3'd3;
                    else if (irq_take)  cause_d = 3'd4;
                    else if (supervisor) begin
                        state_d = StIretRd;
                    end else begin
                        // IRET from user mode is an illegal instruction.
                        cause_d = 3'd3;
                    end
                end
            end
            StFlush:      state_d = StSaveEpc;
            StSaveEpc:    state_d = StSaveBad;
            StSaveBad:    state_d = StSaveCause;
            StSaveCause:  state_d = StSaveStatus;
            StSaveStatus: state_d = StRedirect;
            StRedirect:   state_d = StIdle;
            StIretRd: begin
                epc_d   = sys_rdata;
                state_d = StIretWr;
            end
            StIretWr:     state_d = StIretRedir;
            StIretRedir:  state_d = StIdle;
            default:      state_d = StIdle;
        endcase
    end

    // Moore outputs; gated by reset so nothing is written once reset asserts.
    always_comb begin
        sys_we      = 1'b0;
        sys_waddr   = '0;
        sys_wdata   = '0;
        flush       = 1'b0;
        stall       = (state_q != StIdle);
        pc_redirect = 1'b0;
        pc_target   = '0;
        unique case (state_q)
            StIdle: ;
            StFlush:  flush = 1'b1;
            StSaveEpc: begin
                sys_we    = 1'b1;
                sys_waddr = EPC_IDX;
                sys_wdata = pc_q;
            end
            StSaveBad: begin
                sys_we    = 1'b1;
                sys_waddr = BAD_IDX;
                // Only TLB misses carry a meaningful address.
                sys_wdata = (cause_q >= 3'd3) ? 32'h0 : addr_q;
            end
            StSaveCause: begin
                sys_we    = 1'b1;
                sys_waddr = CAUSE_IDX;
                sys_wdata = {29'b0, cause_q};
            end
            StSaveStatus: begin
                sys_we    = 1'b1;
                sys_waddr = STATUS_IDX;
                sys_wdata = 32'h1;
            end
            StRedirect: begin
                pc_redirect = 1'b1;
                pc_target   = HANDLER_VEC;
            end
            StIretRd: flush = 1'b1;
            StIretWr: begin
                sys_we    = 1'b1;
                sys_waddr = STATUS_IDX;
                sys_wdata = 32'h0;
            end
            StIretRedir: begin
                pc_redirect = 1'b1;
                pc_target   = epc_q;
            end
            default: ;
        endcase
        if (!rst_n) begin
            sys_we      = 1'b0;
            sys_waddr   = '0;
            sys_wdata   = '0;
            flush       = 1'b0;
            stall       = 1'b0;
            pc_redirect = 1'b0;
            pc_target   = '0;
        end
    end

endmodule

// File: tb/tb_exception_sequencer.sv
module tb_exception_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        itlb_miss, dtlb_miss, illegal, irq, iret, supervisor;
    logic [31:0] fault_pc, fault_addr, sys_rdata;
    logic        sys_we, flush, stall, pc_redirect;
    logic [4:0]  sys_waddr, sys_raddr;
    logic [31:0] sys_wdata, pc_target;

    always #5 clk = ~clk;

    exception_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .itlb_miss   (itlb_miss),
        .dtlb_miss   (dtlb_miss),
        .illegal     (illegal),
        .irq         (irq),
        .iret        (iret),
        .fault_pc    (fault_pc),
        .fault_addr  (fault_addr),
        .supervisor  (supervisor),
        .sys_we      (sys_we),
        .sys_waddr   (sys_waddr),
        .sys_wdata   (sys_wdata),
        .sys_raddr   (sys_raddr),
        .sys_rdata   (sys_rdata),
        .flush       (flush),
        .stall       (stall),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [72:0] v;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    wire [72:0] obs = {flush, stall, sys_we, sys_waddr, sys_wdata, pc_redirect, pc_target};

    task automatic check_eq(input string tag, input logic [72:0] got, input logic [72:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [72:0] mk(input logic fl, input logic st, input logic we,
                                       input logic [4:0] a, input logic [31:0] d,
                                       input logic rd, input logic [31:0] t);
        return {fl, st, we, a, d, rd, t};
    endfunction

    task automatic push(input int c, input logic [72:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    // Full entry sequence for an event sampled at the edge ending cycle c.
    task automatic push_entry(input int c, input logic [31:0] pc, input logic [31:0] bad,
                              input logic [2:0] cause);
        push(c + 1, mk(1, 1, 0, 5'd0, 32'h0, 0, 32'h0));
        push(c + 2, mk(0, 1, 1, 5'd0, pc, 0, 32'h0));
        push(c + 3, mk(0, 1, 1, 5'd1, bad, 0, 32'h0));
        push(c + 4, mk(0, 1, 1, 5'd2, {29'b0, cause}, 0, 32'h0));
        push(c + 5, mk(0, 1, 1, 5'd4, 32'h1, 0, 32'h0));
        push(c + 6, mk(0, 1, 0, 5'd0, 32'h0, 1, 32'h2000));
    endtask

    // Every non-idle output cycle must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && obs != '0) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_output", obs, '0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("cycle", 73'(cyc), 73'(mon_e.cyc));
                check_eq("outputs", obs, mon_e.v);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse events for one cycle; c is the cycle in which they are presented.
    task automatic fire(input logic d, input logic i, input logic il, input logic r,
                        input logic [31:0] pc, input logic [31:0] addr, output int c);
        step();
        dtlb_miss  = d;
        itlb_miss  = i;
        illegal    = il;
        iret       = r;
        fault_pc   = pc;
        fault_addr = addr;
        c          = cyc;
        step();
        dtlb_miss = 0;
        itlb_miss = 0;
        illegal   = 0;
        iret      = 0;
    endtask

    initial begin
        int c;
        rst_n = 0; itlb_miss = 0; dtlb_miss = 0; illegal = 0; irq = 0; iret = 0;
        supervisor = 0; fault_pc = 0; fault_addr = 0; sys_rdata = 0;
        repeat (3) step();
        check_eq("reset_outputs", obs, '0);
        check_eq("reset_raddr", 73'(sys_raddr), 73'(0));
        rst_n = 1;
        step();
        check_eq("idle_outputs", obs, '0);

        // DTLB miss, with a stray event while busy that must be ignored.
        fire(1, 0, 0, 0, 32'h100, 32'hDEAD0000, c);
        push_entry(c, 32'h100, 32'hDEAD0000, 3'd2);
        step();
        itlb_miss = 1;
        step();
        itlb_miss = 0;
        repeat (6) step();

        // Priority: DTLB beats ITLB and ILLEGAL.
        fire(1, 1, 1, 0, 32'h200, 32'h3000, c);
        push_entry(c, 32'h200, 32'h3000, 3'd2);
        repeat (8) step();

        // ITLB with IRET in the same cycle: exception wins.
        supervisor = 1;
        fire(0, 1, 0, 1, 32'h240, 32'h7000, c);
        push_entry(c, 32'h240, 32'h7000, 3'd1);
        repeat (8) step();

        // Illegal instruction in supervisor mode: BADADDR is 0.
        fire(0, 0, 1, 0, 32'h280, 32'h9999, c);
        push_entry(c, 32'h280, 32'h0, 3'd3);
        repeat (8) step();

        // IRET from supervisor.
        sys_rdata = 32'h104;
        fire(0, 0, 0, 1, 32'h500, 32'h0, c);
        push(c + 1, mk(1, 1, 0, 5'd0, 32'h0, 0, 32'h0));
        push(c + 2, mk(0, 1, 1, 5'd4, 32'h0, 0, 32'h0));
        push(c + 3, mk(0, 1, 0, 5'd0, 32'h0, 1, 32'h104));
        repeat (5) step();
        sys_rdata = 32'h0;

        // IRET from user mode -> illegal.
        supervisor = 0;
        fire(0, 0, 0, 1, 32'h300, 32'h5555, c);
        push_entry(c, 32'h300, 32'h0, 3'd3);
        repeat (8) step();

        // Reset asserted during SAVE_BAD.
        fire(1, 0, 0, 0, 32'h400, 32'h4444, c);
        push(c + 1, mk(1, 1, 0, 5'd0, 32'h0, 0, 32'h0));
        push(c + 2, mk(0, 1, 1, 5'd0, 32'h400, 0, 32'h0));
        step();
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        check_eq("post_reset_outputs", obs, '0);
        check_eq("post_reset_raddr", 73'(sys_raddr), 73'(0));
        repeat (8) step();
        check_eq("post_reset_no_writes", 73'(exp_q.size()), 73'(0));

`ifdef EXC_IRQ_EN
        supervisor = 1;
        irq        = 1;
        fault_pc   = 32'h600;
        fault_addr = 32'h6666;
        repeat (4) step();
        check_eq("irq_sup_stall", 73'(stall), 73'(0));
        supervisor = 0;
        c          = cyc;
        step();
        irq = 0;
        push_entry(c, 32'h600, 32'h0, 3'd4);
        repeat (8) step();
`else
        irq = 1;
        repeat (4) step();
        check_eq("irq_ignored_stall", 73'(stall), 73'(0));
        check_eq("irq_ignored_outputs", obs, '0);
        irq = 0;
`endif

        repeat (10) step();
        check_eq("scoreboard_drained", 73'(exp_q.size()), 73'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
